// File: rtl/rvvi_tx_scheduler.sv
// RVVI transmit scheduler: arbitrates active-list replays over fresh trace packets,
// holds each packet on the Tx port until accepted, and times out missing host acks.
module rvvi_tx_scheduler #(
    parameter int unsigned WIDTH = 792,
    parameter int unsigned TOW   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             NewValid,
    input  logic [WIDTH-1:0] NewData,
    output logic             NewStall,
    output logic             AlWen,
    input  logic             AlFull,
    input  logic             AlEmpty,
    input  logic             AlWait,
    input  logic             AlReplayValid,
    input  logic [WIDTH-1:0] AlReplayData,
    output logic             AlReplayStall,
    output logic             TxValid,
    output logic [WIDTH-1:0] TxData,
    input  logic             TxReady,
    input  logic             AckValid,
    input  logic [TOW-1:0]   TimeoutLimit,
    output logic             TimeoutPulse,
    output logic [31:0]      ReplayCount
);

    localparam logic [1:0] IDLE        = 2'd0;
    localparam logic [1:0] SEND_NEW    = 2'd1;
    localparam logic [1:0] SEND_REPLAY = 2'd2;

    localparam logic [TOW-1:0] TO_MAX = {TOW{1'b1}};

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] tx_data_q, tx_data_d;
    logic [31:0]      replay_cnt_q, replay_cnt_d;
    logic [TOW-1:0]   to_cnt_q, to_cnt_d;
    logic             idle;
    logic             new_ok;
    logic             to_hit;

    // Fresh packets only enter when idle, no replay pending and the active list can take them.
    assign idle          = (state_q == IDLE);
    assign new_ok        = ~reset & idle & ~AlReplayValid & ~AlFull & ~AlWait;
    assign NewStall      = ~new_ok;
    assign AlWen         = NewValid & new_ok;
    assign AlReplayStall = reset | ~idle;
    assign TxValid       = ~idle;
    assign TxData        = tx_data_q;
    assign ReplayCount   = replay_cnt_q;

    // An ack arriving on the limit cycle suppresses the pulse.
    assign to_hit       = ~reset & (TimeoutLimit != '0) & (to_cnt_q == TimeoutLimit) & ~AckValid;
    assign TimeoutPulse = to_hit;

    always_comb begin
        state_d      = state_q;
        tx_data_d    = tx_data_q;
        replay_cnt_d = replay_cnt_q;
        to_cnt_d     = to_cnt_q;

        case (state_q)
            IDLE: begin
                if (AlReplayValid) begin
                    tx_data_d = AlReplayData;
                    state_d   = SEND_REPLAY;
                end else if (AlWen) begin
                    tx_data_d = NewData;
                    state_d   = SEND_NEW;
                end
            end
            SEND_NEW: begin
                if (TxReady) begin
                    state_d = IDLE;
                end
            end
            SEND_REPLAY: begin
                if (TxReady) begin
                    state_d      = IDLE;
                    replay_cnt_d = replay_cnt_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Saturating ack-timeout counter.
        if (AlEmpty || AckValid || (TimeoutLimit == '0) || to_hit) begin
            to_cnt_d = '0;
        end else if (to_cnt_q != TO_MAX) begin
            to_cnt_d = to_cnt_q + TOW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            tx_data_q    <= '0;
            replay_cnt_q <= '0;
            to_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            tx_data_q    <= tx_data_d;
            replay_cnt_q <= replay_cnt_d;
            to_cnt_q     <= to_cnt_d;
        end
    end

endmodule

// File: tb/tb_rvvi_tx_scheduler.sv
// Directed bench for rvvi_tx_scheduler: arbitration, Tx hold, replay count, ack timeout.
module tb_rvvi_tx_scheduler;

    localparam int unsigned WIDTH = 792;
    localparam int unsigned TOW   = 4;

    logic             clk;
    logic             reset;
    logic             NewValid;
    logic [WIDTH-1:0] NewData;
    logic             NewStall;
    logic             AlWen;
    logic             AlFull;
    logic             AlEmpty;
    logic             AlWait;
    logic             AlReplayValid;
    logic [WIDTH-1:0] AlReplayData;
    logic             AlReplayStall;
    logic             TxValid;
    logic [WIDTH-1:0] TxData;
    logic             TxReady;
    logic             AckValid;
    logic [TOW-1:0]   TimeoutLimit;
    logic             TimeoutPulse;
    logic [31:0]      ReplayCount;

    int n_chk  = 0;
    int n_pass = 0;

    rvvi_tx_scheduler #(.WIDTH(WIDTH), .TOW(TOW)) dut (
        .clk           (clk),
        .reset         (reset),
        .NewValid      (NewValid),
        .NewData       (NewData),
        .NewStall      (NewStall),
        .AlWen         (AlWen),
        .AlFull        (AlFull),
        .AlEmpty       (AlEmpty),
        .AlWait        (AlWait),
        .AlReplayValid (AlReplayValid),
        .AlReplayData  (AlReplayData),
        .AlReplayStall (AlReplayStall),
        .TxValid       (TxValid),
        .TxData        (TxData),
        .TxReady       (TxReady),
        .AckValid      (AckValid),
        .TimeoutLimit  (TimeoutLimit),
        .TimeoutPulse  (TimeoutPulse),
        .ReplayCount   (ReplayCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        logic [63:0] o64;
        logic [63:0] e64;
        o64 = obs[63:0];
        e64 = exp[63:0];
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, o64, e64);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired after %0d checks", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        NewValid      = 1'b1;
        NewData       = WIDTH'(8'hA5);
        AlFull        = 1'b0;
        AlEmpty       = 1'b1;
        AlWait        = 1'b0;
        AlReplayValid = 1'b0;
        AlReplayData  = '0;
        TxReady       = 1'b0;
        AckValid      = 1'b0;
        TimeoutLimit  = '0;

        // Reset state, with a new packet offered that must not be written.
        tick(); tick(); #1;
        chk("rst_txvalid", TxValid, 1'b0);
        chk("rst_txdata", TxData, '0);
        chk("rst_replaycount", ReplayCount, '0);
        chk("rst_alwen", AlWen, 1'b0);
        chk("rst_replaystall", AlReplayStall, 1'b1);
        chk("rst_timeout", TimeoutPulse, 1'b0);

        // Single new packet 0xA5 with TxReady high.
        tick(); reset = 1'b0; NewValid = 1'b1; NewData = WIDTH'(8'hA5); TxReady = 1'b1; #1;
        chk("new_c0_alwen", AlWen, 1'b1);
        chk("new_c0_newstall", NewStall, 1'b0);
        chk("new_c0_txvalid", TxValid, 1'b0);
        tick(); NewValid = 1'b0; #1;
        chk("new_c1_txvalid", TxValid, 1'b1);
        chk("new_c1_txdata", TxData, WIDTH'(8'hA5));
        chk("new_c1_replaystall", AlReplayStall, 1'b1);
        chk("new_c1_newstall", NewStall, 1'b1);
        tick(); #1;
        chk("new_c2_txvalid", TxValid, 1'b0);
        chk("new_c2_replaystall", AlReplayStall, 1'b0);

        // Replay and new packet together: replay first, held 5 cycles by TxReady=0.
        tick(); NewValid = 1'b1; NewData = WIDTH'(8'h11);
        AlReplayValid = 1'b1; AlReplayData = WIDTH'(8'h22); TxReady = 1'b0; #1;
        chk("arb_newstall", NewStall, 1'b1);
        chk("arb_alwen", AlWen, 1'b0);
        chk("arb_replaystall", AlReplayStall, 1'b0);
        tick(); AlReplayValid = 1'b0; #1;
        chk("rep_replaycount0", ReplayCount, 32'd0);
        for (int i = 0; i < 5; i++) begin
            chk("hold_txvalid", TxValid, 1'b1);
            chk("hold_txdata", TxData, WIDTH'(8'h22));
            chk("hold_replaystall", AlReplayStall, 1'b1);
            chk("hold_alwen", AlWen, 1'b0);
            tick(); #1;
        end
        TxReady = 1'b1; #1;
        chk("rep_pre_count", ReplayCount, 32'd0);
        tick(); #1;
        chk("rep_post_count", ReplayCount, 32'd1);
        chk("rep_post_txvalid", TxValid, 1'b0);
        chk("arb_new_alwen", AlWen, 1'b1);
        tick(); NewValid = 1'b0; #1;
        chk("arb_new_txvalid", TxValid, 1'b1);
        chk("arb_new_txdata", TxData, WIDTH'(8'h11));
        tick(); #1;
        chk("arb_new_done", TxValid, 1'b0);
        chk("arb_new_count", ReplayCount, 32'd1);

        // Active list full / replay-in-progress block new packets.
        NewValid = 1'b1; AlFull = 1'b1; #1;
        chk("full_newstall", NewStall, 1'b1);
        chk("full_alwen", AlWen, 1'b0);
        AlFull = 1'b0; AlWait = 1'b1; #1;
        chk("wait_newstall", NewStall, 1'b1);
        chk("wait_alwen", AlWen, 1'b0);
        AlWait = 1'b0; NewValid = 1'b0;

        // Second replay, then reset in the middle of a third.
        tick(); AlReplayValid = 1'b1; AlReplayData = WIDTH'(8'h44); TxReady = 1'b1;
        tick(); AlReplayValid = 1'b0; #1;
        chk("rep2_txdata", TxData, WIDTH'(8'h44));
        tick(); #1;
        chk("rep2_count", ReplayCount, 32'd2);
        AlReplayValid = 1'b1; AlReplayData = WIDTH'(8'h55); TxReady = 1'b0;
        tick(); AlReplayValid = 1'b0; reset = 1'b1; #1;
        chk("rstmid_txvalid_before", TxValid, 1'b1);
        chk("rstmid_replaystall", AlReplayStall, 1'b1);
        tick(); #1;
        chk("rstmid_txvalid", TxValid, 1'b0);
        chk("rstmid_count", ReplayCount, 32'd0);
        chk("rstmid_txdata", TxData, '0);

        // Timeout limit 4, no acks: pulses in cycles 4 and 9.
        TimeoutLimit = 4'd4; AlEmpty = 1'b0;
        tick(); tick(); reset = 1'b0; #1;
        for (int k = 0; k <= 10; k++) begin
            chk($sformatf("to_c%0d", k), TimeoutPulse, (k == 4 || k == 9) ? 1'b1 : 1'b0);
            tick(); #1;
        end

        // Ack in cycle 3 pushes the first pulse out to cycle 8.
        reset = 1'b1;
        tick(); tick(); reset = 1'b0; #1;
        for (int k = 0; k <= 9; k++) begin
            AckValid = (k == 3); #1;
            chk($sformatf("ack_c%0d", k), TimeoutPulse, (k == 8) ? 1'b1 : 1'b0);
            tick(); #1;
        end
        AckValid = 1'b0;

        // Limit lowered below the count: counter must saturate at 15, not wrap.
        reset = 1'b1; TimeoutLimit = 4'd10;
        tick(); tick(); reset = 1'b0; #1;
        for (int k = 0; k < 8; k++) begin
            tick(); #1;
        end
        TimeoutLimit = 4'd3;
        for (int k = 0; k < 12; k++) begin
            #1;
            chk($sformatf("sat_c%0d", k), TimeoutPulse, 1'b0);
            tick(); #1;
        end
        TimeoutLimit = 4'd15; #1;
        chk("sat_hold_max", TimeoutPulse, 1'b1);
        AckValid = 1'b1; #1;
        chk("sat_ack_wins", TimeoutPulse, 1'b0);
        AckValid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
